// File: rtl/instr_exec_regfile_if.sv
// Instruction/readback bus between an instruction source and instr_exec_regfile.
// The master drives instructions and read pointers; the slave returns busy and entry contents.
interface instr_exec_regfile_if #(
    parameter int unsigned OP_WIDTH = 32,
    parameter int unsigned DEPTH    = 32
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic                load_en;
    logic [3:0]          opcode;
    logic [OP_WIDTH-1:0] operand_a;
    logic [OP_WIDTH-1:0] operand_b;
    logic [ADDR_W-1:0]   write_pointer;
    logic [ADDR_W-1:0]   read_pointer;
    logic                busy;
    logic                rd_valid;
    logic [3:0]          rd_opcode;
    logic [OP_WIDTH-1:0] rd_op_a;
    logic [OP_WIDTH-1:0] rd_op_b;
    logic [OP_WIDTH-1:0] rd_result;
    logic [2:0]          rd_flags;

    modport master (
        output load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
        input  busy, rd_valid, rd_opcode, rd_op_a, rd_op_b, rd_result, rd_flags
    );

    modport slave (
        input  load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
        output busy, rd_valid, rd_opcode, rd_op_a, rd_op_b, rd_result, rd_flags
    );
endinterface

// File: rtl/instr_exec_regfile.sv
// Executes signed opcode/operand pairs and stores opcode, operands, result and flags
// in a DEPTH-entry register file; DIV/MOD use an iterative restoring divider.
module instr_exec_regfile #(
    parameter int unsigned OP_WIDTH = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input logic                 clk,
    input logic                 reset,
    instr_exec_regfile_if.slave bus
);
    localparam int unsigned W     = OP_WIDTH;
    localparam int unsigned CNT_W = $clog2(OP_WIDTH);

    typedef enum logic [3:0] {
        OP_ZERO  = 4'd0,
        OP_PASSA = 4'd1,
        OP_PASSB = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_MULT  = 4'd5,
        OP_DIV   = 4'd6,
        OP_MOD   = 4'd7
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DIV_RUN  = 2'd1,
        S_DIV_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic              busy_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [W-1:0]      quo_q, rem_q, dvs_q;
    logic              a_neg_q, b_neg_q, dbz_q;
    logic [3:0]        d_opc_q;
    logic [W-1:0]      d_a_q, d_b_q;
    logic [ADDR_W-1:0] d_ptr_q;

    logic [3:0]        opc_mem_q [DEPTH];
    logic [W-1:0]      a_mem_q   [DEPTH];
    logic [W-1:0]      b_mem_q   [DEPTH];
    logic [W-1:0]      res_mem_q [DEPTH];
    logic [2:0]        flg_mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;

    logic              rd_valid_q;
    logic [3:0]        rd_opc_q;
    logic [W-1:0]      rd_a_q, rd_b_q, rd_res_q;
    logic [2:0]        rd_flg_q;

    logic              accept_c, is_div_c;
    logic [W:0]        sum_c, diff_c;
    logic [2*W-1:0]    prod_c;
    logic [W-1:0]      sc_res_c;
    logic [2:0]        sc_flags_c;
    logic [W-1:0]      a_mag_c, b_mag_c, shift_c, q_fin_c, r_fin_c;
    logic              ge_c, q_neg_c, div_ovf_c;
    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_ptr_c;
    logic [3:0]        wr_opc_c;
    logic [W-1:0]      wr_a_c, wr_b_c, wr_res_c;
    logic [2:0]        wr_flg_c;

    assign accept_c = (state_q == S_IDLE) && bus.load_en && !busy_q;
    assign is_div_c = (bus.opcode == OP_DIV) || (bus.opcode == OP_MOD);

    // Single-cycle datapath at full precision; overflow when the truncated value loses information.
    always_comb begin
        sum_c      = {bus.operand_a[W-1], bus.operand_a} + {bus.operand_b[W-1], bus.operand_b};
        diff_c     = {bus.operand_a[W-1], bus.operand_a} - {bus.operand_b[W-1], bus.operand_b};
        prod_c     = {{W{bus.operand_a[W-1]}}, bus.operand_a} * {{W{bus.operand_b[W-1]}}, bus.operand_b};
        sc_res_c   = '0;
        sc_flags_c = '0;
        case (bus.opcode)
            OP_ZERO:  sc_res_c = '0;
            OP_PASSA: sc_res_c = bus.operand_a;
            OP_PASSB: sc_res_c = bus.operand_b;
            OP_ADD: begin
                sc_res_c      = sum_c[W-1:0];
                sc_flags_c[0] = sum_c[W] ^ sum_c[W-1];
            end
            OP_SUB: begin
                sc_res_c      = diff_c[W-1:0];
                sc_flags_c[0] = diff_c[W] ^ diff_c[W-1];
            end
            OP_MULT: begin
                sc_res_c      = prod_c[W-1:0];
                sc_flags_c[0] = prod_c[2*W-1:W] != {W{prod_c[W-1]}};
            end
            OP_DIV, OP_MOD: sc_res_c = '0;
            default: sc_flags_c[2] = 1'b1;
        endcase
    end

    // Divider magnitudes, restoring step and final sign application.
    always_comb begin
        a_mag_c   = bus.operand_a[W-1] ? ('0 - bus.operand_a) : bus.operand_a;
        b_mag_c   = bus.operand_b[W-1] ? ('0 - bus.operand_b) : bus.operand_b;
        shift_c   = {rem_q[W-2:0], quo_q[W-1]};
        ge_c      = shift_c >= dvs_q;
        q_neg_c   = a_neg_q ^ b_neg_q;
        q_fin_c   = q_neg_c ? ('0 - quo_q) : quo_q;
        r_fin_c   = a_neg_q ? ('0 - rem_q) : rem_q;
        div_ovf_c = !q_neg_c && quo_q[W-1];
    end

    // Single write port: divider completion or a single-cycle accept, never both.
    always_comb begin
        wr_en_c  = 1'b0;
        wr_ptr_c = bus.write_pointer;
        wr_opc_c = bus.opcode;
        wr_a_c   = bus.operand_a;
        wr_b_c   = bus.operand_b;
        wr_res_c = sc_res_c;
        wr_flg_c = sc_flags_c;
        if (state_q == S_DIV_DONE) begin
            wr_en_c  = 1'b1;
            wr_ptr_c = d_ptr_q;
            wr_opc_c = d_opc_q;
            wr_a_c   = d_a_q;
            wr_b_c   = d_b_q;
            wr_res_c = dbz_q ? '0 : ((d_opc_q == OP_DIV) ? q_fin_c : r_fin_c);
            wr_flg_c = {1'b0, dbz_q, !dbz_q && (d_opc_q == OP_DIV) && div_ovf_c};
        end else if (accept_c && !is_div_c) begin
            wr_en_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            dbz_q      <= 1'b0;
            d_opc_q    <= '0;
            d_a_q      <= '0;
            d_b_q      <= '0;
            d_ptr_q    <= '0;
            valid_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_opc_q   <= '0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            rd_res_q   <= '0;
            rd_flg_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                opc_mem_q[i] <= '0;
                a_mem_q[i]   <= '0;
                b_mem_q[i]   <= '0;
                res_mem_q[i] <= '0;
                flg_mem_q[i] <= '0;
            end
        end else begin
            // Read-before-write: nonblocking update leaves the old entry visible this edge.
            rd_valid_q <= valid_q[bus.read_pointer];
            rd_opc_q   <= opc_mem_q[bus.read_pointer];
            rd_a_q     <= a_mem_q[bus.read_pointer];
            rd_b_q     <= b_mem_q[bus.read_pointer];
            rd_res_q   <= res_mem_q[bus.read_pointer];
            rd_flg_q   <= flg_mem_q[bus.read_pointer];

            if (wr_en_c) begin
                valid_q[wr_ptr_c]   <= 1'b1;
                opc_mem_q[wr_ptr_c] <= wr_opc_c;
                a_mem_q[wr_ptr_c]   <= wr_a_c;
                b_mem_q[wr_ptr_c]   <= wr_b_c;
                res_mem_q[wr_ptr_c] <= wr_res_c;
                flg_mem_q[wr_ptr_c] <= wr_flg_c;
            end

            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (accept_c && is_div_c) begin
                        d_opc_q <= bus.opcode;
                        d_a_q   <= bus.operand_a;
                        d_b_q   <= bus.operand_b;
                        d_ptr_q <= bus.write_pointer;
                        a_neg_q <= bus.operand_a[W-1];
                        b_neg_q <= bus.operand_b[W-1];
                        quo_q   <= a_mag_c;
                        rem_q   <= '0;
                        dvs_q   <= b_mag_c;
                        cnt_q   <= '0;
                        dbz_q   <= (bus.operand_b == '0);
                        state_q <= (bus.operand_b == '0) ? S_DIV_DONE : S_DIV_RUN;
                    end
                end
                S_DIV_RUN: begin
                    busy_q <= 1'b1;
                    quo_q  <= {quo_q[W-2:0], ge_c};
                    rem_q  <= ge_c ? (shift_c - dvs_q) : shift_c;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(OP_WIDTH - 1)) state_q <= S_DIV_DONE;
                end
                S_DIV_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_opcode = rd_opc_q;
    assign bus.rd_op_a   = rd_a_q;
    assign bus.rd_op_b   = rd_b_q;
    assign bus.rd_result = rd_res_q;
    assign bus.rd_flags  = rd_flg_q;
endmodule

// File: tb/tb_instr_exec_regfile.sv
// Self-checking bench for instr_exec_regfile: directed corner cases plus randomized
// instructions compared against an integer-arithmetic reference model of the register file.
module tb_instr_exec_regfile;
    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned EW    = 1 + 4 + 3 * W + 3;

    localparam logic [3:0] OP_ZERO = 4'd0, OP_PASSA = 4'd1, OP_PASSB = 4'd2, OP_ADD = 4'd3,
                           OP_SUB = 4'd4, OP_MULT = 4'd5, OP_DIV = 4'd6, OP_MOD = 4'd7;

    typedef logic [EW-1:0] ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_exec_regfile_if #(.OP_WIDTH(W), .DEPTH(DEPTH)) bus ();
    instr_exec_regfile #(.OP_WIDTH(W), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks   = 0;
    int failures = 0;

    logic         m_v   [DEPTH];
    logic [3:0]   m_opc [DEPTH];
    logic [W-1:0] m_a   [DEPTH];
    logic [W-1:0] m_b   [DEPTH];
    logic [W-1:0] m_res [DEPTH];
    logic [2:0]   m_fl  [DEPTH];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_v[i] = 1'b0; m_opc[i] = '0; m_a[i] = '0; m_b[i] = '0; m_res[i] = '0; m_fl[i] = '0;
        end
    endfunction

    // Reference semantics: exact integer result, truncated, overflow if truncation changed the value.
    function automatic void model_write(input logic [AW-1:0] p, input logic [3:0] op,
                                        input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, full;
        logic [W-1:0] res;
        logic [2:0] fl;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        full = 0;
        fl = 3'b000;
        case (op)
            OP_ZERO:  full = 0;
            OP_PASSA: full = sa;
            OP_PASSB: full = sb;
            OP_ADD:   full = sa + sb;
            OP_SUB:   full = sa - sb;
            OP_MULT:  full = sa * sb;
            OP_DIV:   if (sb == 0) fl[1] = 1'b1; else full = sa / sb;
            OP_MOD:   if (sb == 0) fl[1] = 1'b1; else full = sa % sb;
            default:  fl[2] = 1'b1;
        endcase
        res = full[W-1:0];
        if (full != longint'($signed(res))) fl[0] = 1'b1;
        m_v[p] = 1'b1; m_opc[p] = op; m_a[p] = a; m_b[p] = b; m_res[p] = res; m_fl[p] = fl;
    endfunction

    function automatic ent_t mdl(input logic [AW-1:0] p);
        return {m_v[p], m_opc[p], m_a[p], m_b[p], m_res[p], m_fl[p]};
    endfunction

    function automatic ent_t cur();
        return {bus.rd_valid, bus.rd_opcode, bus.rd_op_a, bus.rd_op_b, bus.rd_result, bus.rd_flags};
    endfunction

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 6))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return '0;
            4: return W'($urandom_range(0, 15));
            5: return 32'hFFFF_FFF0 | W'($urandom_range(0, 15));
            default: return W'($urandom());
        endcase
    endfunction

    // Presents one instruction for a single edge and records it in the model.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [AW-1:0] wp);
        bus.load_en = 1'b1; bus.opcode = op; bus.operand_a = a; bus.operand_b = b; bus.write_pointer = wp;
        tick();
        bus.load_en = 1'b0;
        model_write(wp, op, a, b);
    endtask

    task automatic read_entry(input logic [AW-1:0] p, output ent_t e);
        bus.read_pointer = p;
        tick();
        e = cur();
    endtask

    task automatic test_reset();
        ent_t e;
        checks++;
        if ({bus.busy, cur()} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%0b entry=%h required all zero", bus.busy, cur());
        end
        for (int p = 0; p < int'(DEPTH); p++) begin
            read_entry(AW'(p), e);
            checks++;
            if (e !== '0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_entry ptr=%0d got=%h busy=%0b required zero", p, e, bus.busy);
            end
        end
    endtask

    task automatic test_add_sub();
        ent_t e;
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3);
        read_entry(5'd3, e);
        checks++;
        if (e !== {1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 3'b001}) begin
            failures++; $display("FAIL add_overflow got=%h required result 80000000 flags 001", e);
        end
        issue(OP_SUB, 32'hFFFF_FFFB, 32'h0000_0007, 5'd4);
        read_entry(5'd4, e);
        checks++;
        if (e !== {1'b1, OP_SUB, 32'hFFFF_FFFB, 32'h0000_0007, 32'hFFFF_FFF4, 3'b000}) begin
            failures++; $display("FAIL sub_neg got=%h required result fffffff4 flags 000", e);
        end
    endtask

    task automatic test_mult();
        ent_t e;
        issue(OP_MULT, 32'h0001_0000, 32'h0001_0000, 5'd5);
        read_entry(5'd5, e);
        checks++;
        if (e !== {1'b1, OP_MULT, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 3'b001}) begin
            failures++; $display("FAIL mult_overflow got=%h required result 0 flags 001", e);
        end
        issue(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 5'd6);
        read_entry(5'd6, e);
        checks++;
        if (e !== {1'b1, OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 3'b000}) begin
            failures++; $display("FAIL mult_neg got=%h required result ffffffeb flags 000", e);
        end
    endtask

    task automatic test_div();
        ent_t e;
        int busy_cycles = 0;
        int fall_k = 0;
        int k = 0;
        logic valid_at_fall = 1'b1;
        bus.read_pointer = 5'd7;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7);
        while (fall_k == 0 && k < 40) begin
            k++;
            tick();
            if (bus.busy) busy_cycles++;
            else if (busy_cycles > 0) begin
                fall_k = k;
                valid_at_fall = bus.rd_valid;
            end
            // Attempted accept while busy must be dropped.
            if (k == 5) begin
                bus.load_en = 1'b1; bus.opcode = OP_ADD; bus.operand_a = 32'd1;
                bus.operand_b = 32'd2; bus.write_pointer = 5'd9;
            end
            if (k == 6) bus.load_en = 1'b0;
        end
        checks++;
        if (busy_cycles != 32 || fall_k != 33) begin
            failures++;
            $display("FAIL div_timing got busy_cycles=%0d fall_edge=%0d required 32 and 33", busy_cycles, fall_k);
        end
        checks++;
        if (valid_at_fall !== 1'b0) begin
            failures++; $display("FAIL div_early_write got rd_valid=%0b before edge 34 required 0", valid_at_fall);
        end
        tick();
        e = cur();
        checks++;
        if (e !== {1'b1, OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 3'b000}) begin
            failures++; $display("FAIL div_neg got=%h required result fffffffd flags 000", e);
        end
        issue(OP_MOD, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8);
        repeat (34) tick();
        read_entry(5'd8, e);
        checks++;
        if (e !== {1'b1, OP_MOD, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 3'b000}) begin
            failures++; $display("FAIL mod_neg got=%h required result ffffffff flags 000", e);
        end
        read_entry(5'd9, e);
        checks++;
        if (e !== '0) begin
            failures++; $display("FAIL busy_drop got=%h required untouched zero entry", e);
        end
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        repeat (34) tick();
        issue(OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        repeat (34) tick();
        read_entry(5'd12, e);
        checks++;
        if (e !== {1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3'b001}) begin
            failures++; $display("FAIL div_min_neg1 got=%h required result 80000000 flags 001", e);
        end
        read_entry(5'd13, e);
        checks++;
        if (e !== {1'b1, OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 3'b000}) begin
            failures++; $display("FAIL mod_min_neg1 got=%h required result 0 flags 000", e);
        end
    endtask

    task automatic test_div_zero();
        ent_t e;
        logic busy_seen;
        bus.read_pointer = 5'd10;
        issue(OP_DIV, 32'd5, 32'd0, 5'd10);
        busy_seen = bus.busy;
        tick();
        busy_seen = busy_seen | bus.busy;
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            failures++; $display("FAIL div0_early got rd_valid=%0b one edge after accept required 0", bus.rd_valid);
        end
        tick();
        busy_seen = busy_seen | bus.busy;
        e = cur();
        checks++;
        if (e !== {1'b1, OP_DIV, 32'd5, 32'd0, 32'd0, 3'b010} || busy_seen !== 1'b0) begin
            failures++; $display("FAIL div_by_zero got=%h busy_seen=%0b required result 0 flags 010 busy 0", e, busy_seen);
        end
        issue(4'd9, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11);
        read_entry(5'd11, e);
        checks++;
        if (e !== {1'b1, 4'd9, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 3'b100}) begin
            failures++; $display("FAIL illegal_op got=%h required result 0 flags 100", e);
        end
    endtask

    task automatic test_random_single();
        ent_t e;
        logic [3:0] op;
        logic [AW-1:0] p;
        int r;
        for (int i = 0; i < 24; i++) begin
            r  = int'($urandom_range(0, 13));
            op = (r < 6) ? 4'(r) : 4'(r + 2);
            p  = AW'($urandom_range(0, DEPTH - 1));
            issue(op, rnd_opnd(), rnd_opnd(), p);
            read_entry(p, e);
            checks++;
            if (e !== mdl(p)) begin
                failures++; $display("FAIL random_single i=%0d ptr=%0d got=%h required=%h", i, p, e, mdl(p));
            end
        end
    endtask

    task automatic test_back_to_back();
        ent_t e;
        int r;
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 13));
            issue((r < 6) ? 4'(r) : 4'(r + 2), rnd_opnd(), rnd_opnd(), AW'($urandom_range(0, DEPTH - 1)));
        end
        for (int p = 0; p < int'(DEPTH); p++) begin
            read_entry(AW'(p), e);
            checks++;
            if (e !== mdl(AW'(p))) begin
                failures++; $display("FAIL back_to_back ptr=%0d got=%h required=%h", p, e, mdl(AW'(p)));
            end
        end
    endtask

    task automatic test_random_div();
        ent_t e;
        logic [AW-1:0] p;
        for (int i = 0; i < 8; i++) begin
            p = AW'($urandom_range(0, DEPTH - 1));
            issue(($urandom_range(0, 1) == 0) ? OP_DIV : OP_MOD, rnd_opnd(), rnd_opnd(), p);
            repeat (34) tick();
            read_entry(p, e);
            checks++;
            if (e !== mdl(p)) begin
                failures++; $display("FAIL random_div i=%0d ptr=%0d got=%h required=%h", i, p, e, mdl(p));
            end
        end
    endtask

    task automatic test_rbw();
        ent_t e, old_e;
        old_e = mdl(5'd3);
        bus.read_pointer = 5'd3;
        issue(OP_SUB, 32'd100, 32'd1, 5'd3);
        e = cur();
        checks++;
        if (e !== old_e) begin
            failures++; $display("FAIL rbw_old got=%h required=%h", e, old_e);
        end
        tick();
        e = cur();
        checks++;
        if (e !== {1'b1, OP_SUB, 32'd100, 32'd1, 32'd99, 3'b000}) begin
            failures++; $display("FAIL rbw_new got=%h required result 99 flags 000", e);
        end
    endtask

    task automatic test_reset_mid_div();
        ent_t e;
        bus.read_pointer = 5'd20;
        issue(OP_DIV, 32'd1000, 32'd3, 5'd20);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        checks++;
        if ({bus.busy, cur()} !== '0) begin
            failures++; $display("FAIL reset_mid_div got busy=%0b entry=%h required all zero", bus.busy, cur());
        end
        repeat (40) tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL reset_mid_div_busy got busy=%0b required 0", bus.busy);
        end
        for (int p = 0; p < int'(DEPTH); p++) begin
            read_entry(AW'(p), e);
            checks++;
            if (e !== mdl(AW'(p))) begin
                failures++; $display("FAIL reset_mid_div_entry ptr=%0d got=%h required=%h", p, e, mdl(AW'(p)));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.load_en = 1'b0; bus.opcode = '0; bus.operand_a = '0; bus.operand_b = '0;
        bus.write_pointer = '0; bus.read_pointer = '0;
        model_clear();
        repeat (3) tick();
        reset = 1'b0;
        test_reset();
        test_add_sub();
        test_mult();
        test_div();
        test_div_zero();
        test_random_single();
        test_back_to_back();
        test_random_div();
        test_rbw();
        test_reset_mid_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
